// File: rtl/kt8_pkg.sv
// kt8_pkg: shared kt8 ALU op codes, alu_seq command codes and state encoding
package kt8_pkg;
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_NOT    = 4'd5;
    localparam logic [3:0] ALU_PASS_B = 4'd6;
    localparam logic [3:0] ALU_PASS_A = 4'd7;
    localparam logic [3:0] ALU_NEG    = 4'd8;
    localparam logic [3:0] ALU_SHL    = 4'd9;
    localparam logic [3:0] ALU_SHR    = 4'd10;
    localparam logic [3:0] ALU_ZERO   = 4'd11;
    localparam logic [3:0] ALU_INC    = 4'd12;
    localparam logic [3:0] ALU_DEC    = 4'd13;
    localparam logic [1:0] CMD_SINGLE = 2'd0;
    localparam logic [1:0] CMD_MUL    = 2'd1;
    localparam logic [1:0] CMD_REPEAT = 2'd2;
    localparam logic [1:0] CMD_RSVD   = 2'd3;
    typedef enum logic [2:0] {
        S_IDLE, S_SINGLE, S_MUL_ADD, S_MUL_SHA, S_MUL_SHB, S_REP, S_DONE
    } state_t;
endpackage

// File: rtl/alu.sv
// alu: kt8 8-bit combinational ALU
// ports: a_i/b_i operands, op_i op code, r_o result (8-bit wrap)
module alu
    import kt8_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [3:0] op_i,
    output logic [7:0] r_o
);
    always_comb begin
        r_o = 8'h00;
        case (op_i)
            ALU_ADD:    r_o = a_i + b_i;
            ALU_SUB:    r_o = a_i - b_i;
            ALU_AND:    r_o = a_i & b_i;
            ALU_OR:     r_o = a_i | b_i;
            ALU_XOR:    r_o = a_i ^ b_i;
            ALU_NOT:    r_o = ~a_i;
            ALU_PASS_B: r_o = b_i;
            ALU_PASS_A: r_o = a_i;
            ALU_NEG:    r_o = 8'h00 - a_i;
            ALU_SHL:    r_o = {a_i[6:0], 1'b0};
            ALU_SHR:    r_o = {1'b0, a_i[7:1]};
            ALU_INC:    r_o = a_i + 8'd1;
            ALU_DEC:    r_o = a_i - 8'd1;
            default:    r_o = 8'h00;
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer driving an external kt8 ALU (single op, shift-add multiply, repeated op)
// ports: clk_i/rst_i (sync, active-high); cmd_valid_i/cmd_ready_o/cmd_i/op_i/a_i/b_i command;
//        alu_a_o/alu_b_o/alu_op_o/alu_r_i ALU link; res_valid_o/res_ready_i/res_o result
module alu_seq
    import kt8_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic [3:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_o,
    output logic [3:0] alu_op_o,
    input  logic [7:0] alu_r_i,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic [7:0] res_o
);
    state_t     st, st_nx;
    logic [7:0] acc, ma, mb;
    logic [3:0] cnt, op_l;
    logic       take;

    assign cmd_ready_o = (st == S_IDLE) && !rst_i;
    assign take        = cmd_valid_i && cmd_ready_o;
    assign res_valid_o = st == S_DONE;
    assign res_o       = acc;

    always_ff @(posedge clk_i)
        st <= rst_i ? S_IDLE : st_nx;

    // ALU drive is decoded from state so alu_r_i is valid at the edge ending each step
    always_comb begin
        st_nx    = st;
        alu_a_o  = 8'h00;
        alu_b_o  = 8'h00;
        alu_op_o = ALU_ZERO;
        case (st)
            S_IDLE: if (take)
                st_nx = cmd_i == CMD_MUL    ? S_MUL_ADD :
                        cmd_i == CMD_REPEAT ? (b_i[3:0] == 4'd0 ? S_DONE : S_REP) : S_SINGLE;
            S_SINGLE: begin
                alu_a_o  = ma;
                alu_b_o  = mb;
                alu_op_o = op_l;
                st_nx    = S_DONE;
            end
            S_MUL_ADD: begin
                alu_a_o  = acc;
                alu_b_o  = ma;
                alu_op_o = mb[0] ? ALU_ADD : ALU_PASS_A;
                st_nx    = S_MUL_SHA;
            end
            S_MUL_SHA: begin
                alu_a_o  = ma;
                alu_op_o = ALU_SHL;
                st_nx    = S_MUL_SHB;
            end
            S_MUL_SHB: begin
                alu_a_o  = mb;
                alu_op_o = ALU_SHR;
                st_nx    = alu_r_i == 8'h00 ? S_DONE : S_MUL_ADD;
            end
            S_REP: begin
                alu_a_o  = acc;
                alu_op_o = op_l;
                st_nx    = cnt == 4'd1 ? S_DONE : S_REP;
            end
            S_DONE: if (res_ready_i) st_nx = S_IDLE;
            default: st_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc  <= 8'h00;
            ma   <= 8'h00;
            mb   <= 8'h00;
            cnt  <= 4'd0;
            op_l <= ALU_ZERO;
        end else begin
            case (st)
                S_IDLE: if (take) begin
                    acc  <= cmd_i == CMD_REPEAT ? a_i : 8'h00;
                    ma   <= a_i;
                    mb   <= b_i;
                    cnt  <= b_i[3:0];
                    op_l <= cmd_i == CMD_RSVD ? ALU_ZERO : op_i;
                end
                S_SINGLE, S_MUL_ADD: acc <= alu_r_i;
                S_MUL_SHA: ma <= alu_r_i;
                S_MUL_SHB: mb <= alu_r_i;
                S_REP: begin
                    acc <= alu_r_i;
                    cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with the kt8 ALU and a latency/result model
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [1:0] cmd_i = 2'd0;
    logic [3:0] op_i = 4'd0;
    logic [7:0] a_i = 8'h00;
    logic [7:0] b_i = 8'h00;
    logic [7:0] alu_a, alu_b, alu_r;
    logic [3:0] alu_op;
    logic       res_valid_o;
    logic       res_ready_i = 1'b0;
    logic [7:0] res_o;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    bit chk_en = 1'b0;

    int       m_ph = 0;
    int       m_left = 0;
    bit [7:0] m_res = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq dut (
        .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_i(cmd_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_r_i(alu_r),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o)
    );

    alu u_alu (.a_i(alu_a), .b_i(alu_b), .op_i(alu_op), .r_o(alu_r));

    function automatic bit [7:0] f_alu(input bit [3:0] op, input bit [7:0] a, input bit [7:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~a;
            4'd6:  return b;
            4'd7:  return a;
            4'd8:  return 8'h00 - a;
            4'd9:  return a << 1;
            4'd10: return a >> 1;
            4'd12: return a + 8'd1;
            4'd13: return a - 8'd1;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit [7:0] f_res(input bit [1:0] c, input bit [3:0] op, input bit [7:0] a, input bit [7:0] b);
        bit [7:0] r;
        int p;
        case (c)
            2'd0: return f_alu(op, a, b);
            2'd1: begin
                p = a * b;
                return p[7:0];
            end
            2'd2: begin
                r = a;
                for (int i = 0; i < int'(b[3:0]); i++) r = f_alu(op, r, 8'h00);
                return r;
            end
            default: return 8'h00;
        endcase
    endfunction

    function automatic int f_lat(input bit [1:0] c, input bit [7:0] b);
        int k;
        if (c == 2'd2) return int'(b[3:0]) + 1;
        if (c != 2'd1) return 2;
        k = 1;
        for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
        return 3 * k + 1;
    endfunction

    always @(posedge clk) begin
        if (rst_i) m_ph <= 0;
        else case (m_ph)
            0: if (cmd_valid_i) begin
                m_res  <= f_res(cmd_i, op_i, a_i, b_i);
                m_ph   <= f_lat(cmd_i, b_i) == 1 ? 2 : 1;
                m_left <= f_lat(cmd_i, b_i) - 1;
            end
            1: begin
                m_left <= m_left - 1;
                if (m_left == 1) m_ph <= 2;
            end
            default: if (res_ready_i) m_ph <= 0;
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d (0x%0h), want %0d (0x%0h)", nm, cyc, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("cmd_ready", int'(cmd_ready_o), int'(m_ph == 0 && !rst_i));
        chk("res_valid", int'(res_valid_o), int'(m_ph == 2));
        if (m_ph == 2) chk("res_o", int'(res_o), int'(m_res));
        if (m_ph != 1) begin
            chk("idle_op", int'(alu_op), 11);
            chk("idle_a", int'(alu_a), 0);
            chk("idle_b", int'(alu_b), 0);
        end
    end

    task automatic issue(input bit [1:0] c, input bit [3:0] o, input bit [7:0] a, input bit [7:0] b, output int n);
        int t;
        @(negedge clk);
        cmd_i = c; op_i = o; a_i = a; b_i = b; cmd_valid_i = 1'b1;
        t = 0;
        while (!cmd_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", int'(cmd_ready_o), 1);
        n = cyc;
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_res(input int n, output int lat);
        int t;
        t = 0;
        while (!res_valid_o && t < 60) begin
            @(negedge clk);
            t++;
        end
        lat = cyc - n;
    endtask

    task automatic run(input string nm, input bit [1:0] c, input bit [3:0] o, input bit [7:0] a,
                       input bit [7:0] b, input int er, input int el);
        int n, lat;
        issue(c, o, a, b, n);
        wait_res(n, lat);
        chk({nm, "_lat"}, lat, el);
        chk({nm, "_res"}, int'(res_o), er);
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
    endtask

    initial begin
        int n, lat;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", int'(cmd_ready_o), 0);
        chk("rst_valid", int'(res_valid_o), 0);
        chk("rst_res", int'(res_o), 0);
        chk("rst_op", int'(alu_op), 11);
        @(posedge clk);
        #1 rst_i = 1'b0;

        run("single_add", 2'd0, 4'd0, 8'd5, 8'd3, 8'h08, 2);
        run("rsvd", 2'd3, 4'd0, 8'd5, 8'd3, 8'h00, 2);
        run("mul_13x11", 2'd1, 4'd0, 8'd13, 8'd11, 8'h8F, 13);
        run("mul_20x20", 2'd1, 4'd0, 8'd20, 8'd20, 8'h90, 16);
        run("mul_ffx0", 2'd1, 4'd0, 8'hFF, 8'h00, 8'h00, 4);
        run("mul_ffxff", 2'd1, 4'd0, 8'hFF, 8'hFF, 8'h01, 25);
        run("rep_shl", 2'd2, 4'd9, 8'h01, 8'd3, 8'h08, 4);
        run("rep_inc", 2'd2, 4'd12, 8'hFE, 8'd3, 8'h01, 4);
        run("rep_zero", 2'd2, 4'd9, 8'h5A, 8'd0, 8'h5A, 1);
        run("rep_shr", 2'd2, 4'd10, 8'h80, 8'd7, 8'h01, 8);
        run("rep_dec", 2'd2, 4'd13, 8'h01, 8'h12, 8'hFF, 3);

        issue(2'd0, 4'd0, 8'd100, 8'd200, n);
        wait_res(n, lat);
        chk("bp_lat", lat, 2);
        cmd_i = 2'd1; a_i = 8'd7; b_i = 8'd7; cmd_valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_res", int'(res_o), 8'd44);
            chk("bp_ready", int'(cmd_ready_o), 0);
        end
        cmd_valid_i = 1'b0;
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        chk("bp_ready_after", int'(cmd_ready_o), 1);
        chk("bp_valid_after", int'(res_valid_o), 0);

        issue(2'd1, 4'd0, 8'd13, 8'd11, n);
        while (cyc < n + 5) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_valid", int'(res_valid_o), 0);
        chk("midrst_op", int'(alu_op), 11);
        chk("midrst_ready", int'(cmd_ready_o), 1);
        run("after_rst", 2'd0, 4'd7, 8'h3C, 8'h11, 8'h3C, 2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Multi-cycle sequencer for the kt8 8-bit combinational ALU. It accepts a command over a valid/ready handshake and drives the ALU's a/b/op inputs one step per cycle, capturing the ALU result into an internal accumulator. It supports a single ALU operation, an 8x8 multiply (low byte only, shift-add), and a repeated unary operation. The ALU itself is instantiated beside this block by the parent, not inside it.

Parameters:
None. Widths are fixed by the kt8 ALU: 8-bit data, 4-bit op.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  block can accept a command
cmd_i  in  2  command: 0=SINGLE, 1=MUL, 2=REPEAT, 3=reserved
op_i  in  4  ALU op code, used by SINGLE and REPEAT
a_i  in  8  operand A
b_i  in  8  operand B; MUL multiplier; REPEAT count in b_i[3:0]
alu_a_o  out  8  to ALU a_i
alu_b_o  out  8  to ALU b_i
alu_op_o  out  4  to ALU op_i
alu_r_i  in  8  from ALU r_o (combinational)
res_valid_o  out  1  result available
res_ready_i  in  1  consumer takes result
res_o  out  8  result (accumulator)

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset: state=IDLE; acc, ma, mb and cnt = 0; res_valid_o=0; res_o=0; alu_a_o=alu_b_o=0; alu_op_o=11 (ZERO). cmd_ready_o is forced to 0 while rst_i=1.
- Reset mid-operation: abandons the command with no result. IDLE is entered on the next edge.
- ALU op codes used: 0 ADD, 7 PASS_A, 9 SHL, 10 SHR, 11 ZERO.
- Idle drive: in IDLE and DONE, alu_op_o=11 and alu_a_o=alu_b_o=0.
- Handshake: cmd_ready_o=1 only in IDLE, with rst_i=0. A command is accepted in cycle N when cmd_valid_i and cmd_ready_o are both 1. Operands are latched at that edge. There is no overlap: cmd_ready_o stays 0 until the result is consumed.
- States: IDLE, SINGLE, MUL_ADD, MUL_SHA, MUL_SHB, REP, DONE.
- SINGLE (cmd 0):
  - Cycle N+1: ALU(op_i, a, b); the result goes to acc; next state DONE.
  - res_valid_o=1 from cycle N+2.
- Reserved (cmd 3): same as SINGLE with op forced to 11, so the result is 0.
- MUL (cmd 1):
  - On accept: acc=0, ma=a_i, mb=b_i.
  - MUL_ADD: if mb[0]=1, drive ADD(acc, ma); else drive PASS_A(acc). The result goes to acc.
  - MUL_SHA: drive SHL(ma); the result goes to ma.
  - MUL_SHB: drive SHR(mb); the result goes to mb. If the new mb==0, next state is DONE; else MUL_ADD.
  - Let k = (index of highest set bit of b_i) + 1, with k=1 when b_i=0. Then MUL states occupy N+1..N+3k and res_valid_o=1 from N+3k+1.
  - Result is (a_i*b_i) mod 256.
- REPEAT (cmd 2):
  - On accept: acc=a_i, cnt=b_i[3:0], latched op=op_i.
  - If cnt==0, go directly to DONE; res_valid_o=1 from N+1 and res_o=a_i.
  - Else, each REP cycle drives ALU(op, acc, 0); the result goes to acc and cnt decrements. When cnt reaches 0, next state is DONE.
  - res_valid_o=1 from N+cnt+1.
  - Binary ops use b=0.
- DONE:
  - res_valid_o=1 and res_o=acc, held stable while res_ready_i=0.
  - On res_valid_o && res_ready_i, go to IDLE. res_valid_o=0 and cmd_ready_o=1 in the next cycle.
  - cmd_valid_i is ignored in DONE.
- ALU outputs: registered or decoded from state and registers. Sampling alu_r_i at the edge ending each ALU cycle is mandatory.
- Arithmetic is 8-bit wrap; no carry or overflow is reported.

Decomposition:
- Shared package kt8_pkg:
  - ALU op code constants (ALU_ADD=0 … ALU_DEC=13).
  - Command codes CMD_SINGLE, CMD_MUL, CMD_REPEAT.
  - State encoding for alu_seq.
- No sub-module: the FSM and datapath registers are in one module. The parent wires it to alu.
- The bench instantiates alu_seq plus the real alu.

Test Plan:
- SINGLE, op=0, a=5, b=3, accepted cycle N -> res_valid_o=1 at N+2, res_o=0x08. cmd_ready_o=0 from N+1 until the result is consumed.
- MUL, a=13, b=11 (k=4) -> res_valid_o at N+13, res_o=0x8F. MUL a=20, b=20 (k=5) -> N+16, res_o=0x90 (400 mod 256).
- MUL, a=0xFF, b=0 -> res_valid_o at N+4, res_o=0x00. MUL a=0xFF, b=0xFF -> N+25, res_o=0x01.
- REPEAT, op=9, a=0x01, b=3 -> res_o=0x08 at N+4. REPEAT op=12, a=0xFE, b=3 -> 0x01 at N+4 (wrap). REPEAT b=0, a=0x5A -> 0x5A at N+1.
- Backpressure: hold res_ready_i=0 for 5 cycles with cmd_valid_i=1 -> res_o stable, cmd_ready_o=0, no second accept. Raise res_ready_i -> cmd_ready_o=1 the next cycle.
- Reset mid-MUL (assert rst_i at N+5 for 1 cycle) -> IDLE, res_valid_o=0, alu_op_o=11. A new SINGLE command then completes normally.
